// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: bit order, active-high segment
// patterns for the digit table, and capture status codes.
package seven_seg_pkg;

    // Segment bit positions within a 7-bit bus (bit0=a ... bit6=g).
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high patterns, written g..a (g is the MSB).
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    // Pattern the encoder shows for an out-of-range value (a+d+g).
    localparam logic [6:0] SEG_RANGE = 7'b1001001;

    // Nibble reported alongside ST_RANGE.
    localparam logic [3:0] RANGE_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_RANGE   = 2'd1,
        ST_UNKNOWN = 2'd2
    } status_e;

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational inverse of the nibble-to-segment encoder table.
// Input is an active-high segment pattern (bit0=a).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_hi,
    output logic [3:0] nibble,
    output status_e    status
);

    // Match against the digit table; anything unrecognised is UNKNOWN.
    always_comb begin
        nibble = '0;
        status = ST_UNKNOWN;
        if (seg_hi == SEG_RANGE) begin
            nibble = RANGE_NIBBLE;
            status = ST_RANGE;
        end
        for (int unsigned i = 0; i < 10; i++) begin
            if (seg_hi == SEG_DIGIT[i]) begin
                nibble = 4'(i);
                status = ST_OK;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Active-low seven-segment readback: glitch filter, decode, and a
// valid/ready output register presenting each new settled pattern once.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segin,
    output logic [3:0] nibble_out,
    output logic [1:0] status_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       dropped_out
);

    localparam int unsigned CNT_W =
        ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [6:0]       seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_q, last_d;
    logic [3:0]       nibble_q, nibble_d;
    logic [1:0]       status_q, status_d;
    logic             valid_q, valid_d;
    logic             dropped_q, dropped_d;

    logic             stable;
    logic             pending;
    logic             emit;
    logic [3:0]       dec_nibble;
    status_e          dec_status;

    seven_seg_decode u_decode (
        .seg_hi (~seg_q),
        .nibble (dec_nibble),
        .status (dec_status)
    );

    // Next-state: sample/stability counter, emit decision, handshake, drop flag.
    always_comb begin
        seg_d = segin;
        if (segin != seg_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        stable  = (cnt_q == CNT_MAX);
        pending = stable && (seg_q != last_q);
        emit    = pending && (!valid_q || ready_in);

        last_d   = last_q;
        nibble_d = nibble_q;
        status_d = status_q;
        valid_d  = valid_q;
        if (emit) begin
            last_d   = seg_q;
            nibble_d = dec_nibble;
            status_d = dec_status;
            valid_d  = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        // A settled, unsent pattern is about to be overwritten by new input.
        dropped_d = dropped_q || (pending && !emit && (segin != seg_q));
    end

    // State registers; reset discards any pending capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= SEG_BLANK;
            cnt_q     <= '0;
            last_q    <= SEG_BLANK;
            nibble_q  <= '0;
            status_q  <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            nibble_q  <= nibble_d;
            status_q  <= status_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign nibble_out  = nibble_q;
    assign status_out  = status_q;
    assign valid_out   = valid_q;
    assign dropped_out = dropped_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: a default build and a
// STABLE_CYCLES=1 build share the clock and reset.
module tb_seven_seg_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [6:0] segin = 7'h7F;
    logic       ready_in = 1'b1;
    logic [3:0] nibble_out;
    logic [1:0] status_out;
    logic       valid_out;
    logic       dropped_out;

    logic [6:0] segin1 = 7'h7F;
    logic       ready1 = 1'b1;
    logic [3:0] nibble1;
    logic [1:0] status1;
    logic       valid1;
    logic       dropped1;

    int tests = 0;
    int fails = 0;

    // expected {nibble, status}
    logic [5:0] exp_q0 [$];
    logic [5:0] exp_q1 [$];

    always #5 clk = ~clk;

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .segin       (segin),
        .nibble_out  (nibble_out),
        .status_out  (status_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .dropped_out (dropped_out)
    );

    seven_seg_capture #(.STABLE_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .segin       (segin1),
        .nibble_out  (nibble1),
        .status_out  (status1),
        .valid_out   (valid1),
        .ready_in    (ready1),
        .dropped_out (dropped1)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: each newly presented capture is popped once and compared.
    logic new0 = 1'b1;
    logic new1 = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            new0 = 1'b1;
        end else begin
            if (valid_out && new0) begin
                if (exp_q0.size() == 0) begin
                    check("dut4_unexpected_emit", {nibble_out, status_out}, 6'h3F);
                    tests++; fails++;
                    $display("FAIL dut4_unexpected_emit: got nibble %0d status %0d, expected none",
                             nibble_out, status_out);
                end else begin
                    logic [5:0] e;
                    e = exp_q0.pop_front();
                    check("dut4_nibble", nibble_out, e[5:2]);
                    check("dut4_status", status_out, e[1:0]);
                end
            end
            new0 = !valid_out || ready_in;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            new1 = 1'b1;
        end else begin
            if (valid1 && new1) begin
                if (exp_q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut1_unexpected_emit: got nibble %0d status %0d, expected none",
                             nibble1, status1);
                end else begin
                    logic [5:0] e;
                    e = exp_q1.pop_front();
                    check("dut1_nibble", nibble1, e[5:2]);
                    check("dut1_status", status1, e[1:0]);
                end
            end
            new1 = !valid1 || ready1;
        end
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_valid", valid_out, 0);
        check("rst_nibble", nibble_out, 0);
        check("rst_status", status_out, 0);
        check("rst_dropped", dropped_out, 0);
        check("rst_valid1", valid1, 0);

        // 1: '3' latency, single-cycle valid, no re-emit
        rst = 1'b0;
        segin = 7'h30;
        exp_q0.push_back({4'd3, 2'd0});
        tick(4);
        check("t1_valid_before_E4", valid_out, 0);
        tick(1);
        check("t1_valid_after_E4", valid_out, 1);
        check("t1_nibble", nibble_out, 3);
        tick(1);
        check("t1_valid_drop", valid_out, 0);
        tick(6);
        check("t1_no_reemit", valid_out, 0);

        // 2: toggling never settles; settled '5' emitted once
        for (int i = 0; i < 10; i++) begin
            segin = (i % 2 == 0) ? 7'h12 : 7'h30;
            tick(2);
        end
        check("t2_no_emit_toggle", valid_out, 0);
        segin = 7'h12;
        exp_q0.push_back({4'd5, 2'd0});
        tick(8);

        // 3: RANGE, UNKNOWN, '8'
        segin = 7'h36;
        exp_q0.push_back({4'hA, 2'd1});
        tick(8);
        segin = 7'h7E;
        exp_q0.push_back({4'h0, 2'd2});
        tick(8);
        segin = 7'h00;
        exp_q0.push_back({4'd8, 2'd0});
        tick(8);
        check("t3_dropped_clear", dropped_out, 0);

        // 4: back-pressure, drop, back-to-back accept+emit
        ready_in = 1'b0;
        segin = 7'h30;
        exp_q0.push_back({4'd3, 2'd0});
        tick(6);
        check("t4_held_valid", valid_out, 1);
        check("t4_held_nibble", nibble_out, 3);
        segin = 7'h12;
        tick(6);
        check("t4_no_drop_yet", dropped_out, 0);
        segin = 7'h78;
        tick(1);
        check("t4_dropped", dropped_out, 1);
        check("t4_nibble_still3", nibble_out, 3);
        tick(5);
        check("t4_valid_still", valid_out, 1);
        check("t4_nibble_hold", nibble_out, 3);
        ready_in = 1'b1;
        exp_q0.push_back({4'd7, 2'd0});
        tick(1);
        check("t4_b2b_valid", valid_out, 1);
        check("t4_b2b_nibble", nibble_out, 7);
        tick(1);
        check("t4_accept_7", valid_out, 0);
        check("t4_dropped_sticky", dropped_out, 1);

        // 5: reset discards pending '0'; re-emitted after release
        ready_in = 1'b0;
        segin = 7'h40;
        exp_q0.push_back({4'd0, 2'd0});
        tick(6);
        check("t5_pending", valid_out, 1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_valid", valid_out, 0);
        check("t5_rst_nibble", nibble_out, 0);
        check("t5_rst_status", status_out, 0);
        check("t5_rst_dropped", dropped_out, 0);
        rst = 1'b0;
        ready_in = 1'b1;
        exp_q0.push_back({4'd0, 2'd0});
        tick(4);
        check("t5_valid_before_E4", valid_out, 0);
        tick(1);
        check("t5_valid_after_E4", valid_out, 1);
        tick(1);
        check("t5_accepted", valid_out, 0);

        // 6: STABLE_CYCLES=1, single-cycle glitch is a real capture
        segin1 = 7'h30;
        exp_q1.push_back({4'd3, 2'd0});
        tick(4);
        check("t6_idle", valid1, 0);
        segin1 = 7'h12;
        exp_q1.push_back({4'd5, 2'd0});
        exp_q1.push_back({4'd3, 2'd0});
        tick(1);
        check("t6_E0_valid", valid1, 0);
        segin1 = 7'h30;
        tick(1);
        check("t6_E1_valid", valid1, 1);
        check("t6_E1_nibble", nibble1, 5);
        tick(1);
        check("t6_E2_valid", valid1, 1);
        check("t6_E2_nibble", nibble1, 3);
        tick(1);
        check("t6_E3_valid", valid1, 0);
        check("t6_dropped1", dropped1, 0);

        tick(4);
        check("sb0_drained", exp_q0.size(), 0);
        check("sb1_drained", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
